// File: rtl/load_size_pkg.sv
// Shared types for the load size unit: RV64 load funct3 encodings, FSM states
// and the natural-alignment test used when MISALIGN_CHECK_EN is defined.
package load_size_pkg;

  localparam int OFF_W = 3;

  typedef enum logic [2:0] {LB, LH, LW, LD, LBU, LHU, LWU, LILL} load_f3_e;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_RESP} ls_state_e;

  function automatic logic is_misaligned(input load_f3_e f3, input logic [OFF_W-1:0] off);
    logic mis;
    mis = 1'b0;
    case (f3)
      LH, LHU: mis = off[0];
      LW, LWU: mis = |off[1:0];
      LD:      mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/load_size_unit_if.sv
// Request, memory and response handshake bundle of the load size unit.
// The slave modport is the unit's view; master is the surrounding pipeline/memory.
interface load_size_unit_if #(
  parameter int XLEN = 64
) ();

  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic            mem_rd_en;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_rvalid;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;

  modport slave (
    input  req_valid, req_funct3, req_addr, mem_rdata, mem_rvalid, rsp_ready,
    output req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_funct3, req_addr, mem_rdata, mem_rvalid, rsp_ready,
    input  req_ready, mem_rd_en, mem_addr, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/load_extract.sv
// Combinational byte/half/word/double extraction with sign or zero extension.
// Bytes shifted beyond the top of the doubleword read as zero.
module load_extract
  import load_size_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  load_f3_e         funct3,
  input  logic [OFF_W-1:0] offset,
  input  logic [XLEN-1:0]  rdata,
  output logic [XLEN-1:0]  data
);

  logic [XLEN-1:0] sh;

  assign sh = rdata >> {offset, 3'b000};

  always_comb begin
    data = '0;
    case (funct3)
      LB:      data = {{(XLEN-8){sh[7]}}, sh[7:0]};
      LH:      data = {{(XLEN-16){sh[15]}}, sh[15:0]};
      LW:      data = {{(XLEN-32){sh[31]}}, sh[31:0]};
      LD:      data = sh;
      LBU:     data = {{(XLEN-8){1'b0}}, sh[7:0]};
      LHU:     data = {{(XLEN-16){1'b0}}, sh[15:0]};
      LWU:     data = {{(XLEN-32){1'b0}}, sh[31:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_size_unit.sv
// Load size unit: one doubleword read per load, bounded wait, extended result.
// Define MISALIGN_CHECK_EN to reject loads that are not naturally aligned.
module load_size_unit
  import load_size_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             reset,
  load_size_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  ls_state_e        state_q, state_d;
  load_f3_e         f3_q, f3_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_rd_en_q, mem_rd_en_d;
  logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]  rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;

  load_f3_e         req_f3;
  logic             reject;
  logic [CNT_W-1:0] cnt_inc;
  logic [XLEN-1:0]  ext_data;

  assign req_f3  = load_f3_e'(bus.req_funct3);
  assign cnt_inc = cnt_q + 1'b1;

  // Requests that never touch memory and go straight to an error response
  always_comb begin
`ifdef MISALIGN_CHECK_EN
    reject = (req_f3 == LILL) || is_misaligned(req_f3, bus.req_addr[OFF_W-1:0]);
`else
    reject = (req_f3 == LILL);
`endif
  end

  load_extract #(.XLEN(XLEN)) u_extract (
    .funct3 (f3_q),
    .offset (off_q),
    .rdata  (bus.mem_rdata),
    .data   (ext_data)
  );

  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    mem_rd_en_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          f3_d  = req_f3;
          off_d = bus.req_addr[OFF_W-1:0];
          if (reject) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = S_READ;
            mem_rd_en_d = 1'b1;
            mem_addr_d  = {bus.req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            cnt_d       = '0;
          end
        end
      end
      S_READ: begin
        // Data arriving on the timeout cycle still counts as a good read
        if (bus.mem_rvalid) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = ext_data;
          rsp_err_d   = 1'b0;
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      f3_q        <= LB;
      off_q       <= '0;
      cnt_q       <= '0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.mem_rd_en = mem_rd_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_load_size_unit.sv
// Scoreboard bench for load_size_unit (TIMEOUT_CYC=4); expected results come
// from an independent byte-wise model and are queued when each load is driven.
module tb_load_size_unit;

  localparam int TO = 4;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
    logic        reject;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   strobe_cnt;
  exp_t sb_q[$];

  load_size_unit_if #(.XLEN(64)) bus ();

  load_size_unit #(.XLEN(64), .TIMEOUT_CYC(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mem_rd_en === 1'b1) strobe_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] f3, input logic [63:0] addr,
                                 input logic [63:0] rdata, input int d);
    exp_t r;
    int   off;
    int   size;
    off      = int'(addr[2:0]);
    size     = 1 << f3[1:0];
    r.reject = (f3 == 3'b111);
`ifdef MISALIGN_CHECK_EN
    if (!r.reject && (off % size) != 0) r.reject = 1'b1;
`endif
    r.data = '0;
    r.err  = 1'b0;
    if (r.reject || d < 0) begin
      r.err = 1'b1;
      return r;
    end
    for (int i = 0; i < size; i++)
      r.data[8*i +: 8] = (off + i < 8) ? rdata[8*(off+i) +: 8] : 8'h00;
    if (!f3[2] && size < 8 && r.data[8*size-1])
      for (int i = size; i < 8; i++) r.data[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  // d = cycles after the strobe cycle at which rvalid is given, -1 = never
  task automatic do_load(input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] rdata, input int d, input int hold);
    exp_t e;
    int   k;
    int   s0;
    int   lat;
    sb_q.push_back(model(f3, addr, rdata, d));
    s0 = strobe_cnt;
    @(negedge clk);
    chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = {$urandom, $urandom};
    if (!sb_q[0].reject) begin
      chk("strobe_now", 64'(bus.mem_rd_en), 64'd1);
      chk("mem_addr", bus.mem_addr, {addr[63:3], 3'b000});
    end
    for (k = 0; k < 40; k++) begin
      if (bus.rsp_valid === 1'b1) break;
      bus.mem_rvalid = (k == d);
      bus.mem_rdata  = (k == d) ? rdata : {$urandom, $urandom};
      @(negedge clk);
    end
    bus.mem_rvalid = 1'b0;
    if (k >= 40) chk("rsp_wait_expired", 64'(k), 64'd0);
    e   = sb_q.pop_front();
    lat = e.reject ? 0 : (d < 0 ? TO : d + 1);
    chk("latency", 64'(k), 64'(lat));
    chk("rsp_data", bus.rsp_data, e.data);
    chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
    chk("strobe_count", 64'(strobe_cnt - s0), e.reject ? 64'd0 : 64'd1);
    for (int h = 0; h < hold; h++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = {$urandom, $urandom};
      @(negedge clk);
      chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold_data", bus.rsp_data, e.data);
      chk("hold_err", 64'(bus.rsp_err), 64'(e.err));
      chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.mem_rvalid = 1'b0;
    bus.rsp_ready  = 1'b1;
    @(negedge clk);
    bus.rsp_ready  = 1'b0;
    chk("rsp_drop", 64'(bus.rsp_valid), 64'd0);
    chk("back_idle", 64'(bus.req_ready), 64'd1);
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    chk("stray_idle", 64'(bus.rsp_valid), 64'd0);
    $display("txn f3=%0d addr=0x%016h d=%0d data=0x%016h err=%0b", f3, addr, d, e.data, e.err);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    chk({tag, "_mem_rd_en"}, 64'(bus.mem_rd_en), 64'd0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 64'd0);
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 64'd0);
    chk({tag, "_rsp_err"}, 64'(bus.rsp_err), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    strobe_cnt     = 0;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.mem_rdata  = '0;
    bus.mem_rvalid = 1'b0;
    bus.rsp_ready  = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    do_load(3'b000, 64'h1003, 64'h0000_0000_8000_0000, 2, 0);
    do_load(3'b101, 64'h2006, 64'hBEEF_0000_0000_0000, 0, 1);
    do_load(3'b001, 64'h2006, 64'hBEEF_0000_0000_0000, 1, 0);
    do_load(3'b111, 64'h5000, 64'h1234_5678_9ABC_DEF0, 0, 0);
    do_load(3'b011, 64'h6000, 64'h0123_4567_89AB_CDEF, -1, 5);
    do_load(3'b010, 64'h3002, 64'h1122_3344_5566_7788, 1, 0);
    do_load(3'b010, 64'h3006, 64'h8899_AABB_CCDD_EEFF, 0, 0);
    do_load(3'b011, 64'h4005, 64'h1122_3344_5566_7788, 0, 0);
    do_load(3'b110, 64'h7004, 64'hF000_0001_0000_0000, 3, 2);
    do_load(3'b011, 64'h7FF8, 64'hFEDC_BA98_7654_3210, 0, 0);

    for (int n = 0; n < 24; n++) begin
      logic [2:0]  f3;
      logic [63:0] a;
      logic [63:0] rd;
      int          d;
      f3 = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      d  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      do_load(f3, a, rd, d, int'($urandom_range(0, 2)));
    end

    // Asynchronous reset in the middle of a read, with memory data arriving afterwards
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_funct3 = 3'b011;
    bus.req_addr   = 64'h9008;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("midread_strobe", 64'(bus.mem_rd_en), 64'd1);
    #2 reset = 1'b1;
    #1 chk_reset_vals("async_reset");
    @(negedge clk);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    chk("post_reset_no_rsp", 64'(bus.rsp_valid), 64'd0);
    chk("post_reset_ready", 64'(bus.req_ready), 64'd1);
    do_load(3'b100, 64'hA001, 64'h0000_0000_0000_9900, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
